// File: rtl/result_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display_if
// Brief    : Result-stage bus toward the BCD display block: capture/next
//            strobes in, seven-segment digits and buffer status out.
// Revision : 1.0 - initial release
// ============================================================================
interface result_bcd_display_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic                     ResultValid;
  logic [DATA_W-1:0]        DataResult;
  logic                     Next;
  logic [6:0]               HEX0;
  logic [6:0]               HEX1;
  logic [6:0]               HEX2;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Overflow;
  logic                     Busy;

  // Upstream / stimulus side
  modport master (
    output ResultValid, DataResult, Next,
    input  HEX0, HEX1, HEX2, Count, Overflow, Busy
  );

  // Display block side
  modport slave (
    input  ResultValid, DataResult, Next,
    output HEX0, HEX1, HEX2, Count, Overflow, Busy
  );
endinterface
`default_nettype wire

// File: rtl/result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display
// Brief    : Buffers rising-edge captures of DataResult in a circular FIFO,
//            converts the oldest entry to three BCD digits with a serial
//            shift-add-3 engine and drives three active-low 7-seg digits.
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_display #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  wire logic              Clock,
  input  wire logic              Resetn,
  result_bcd_display_if.slave    bus
);

  localparam int         c_PTR_W = $clog2(DEPTH);
  localparam int         c_CNT_W = $clog2(DEPTH) + 1;
  localparam int         c_CYC_W = $clog2(DATA_W + 1);
  localparam logic [6:0] c_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic                r_rv_q;
  logic                r_nx_q;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;
  logic                r_head_chg;
  logic                r_pending;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_pending_nxt;
  logic [DATA_W-1:0]   r_sh;
  logic [11:0]         r_bcd;
  logic [11:0]         w_bcd_adj;
  logic [c_CYC_W-1:0]  r_cnt;
  logic [6:0]          r_hex0;
  logic [6:0]          r_hex1;
  logic [6:0]          r_hex2;

  logic w_cap;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_blank;
  logic w_head_upd;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Out-of-range codes cannot come out of a valid conversion; show blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return c_BLANK;
    endcase
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_cap   = bus.ResultValid & ~r_rv_q;
  assign w_pop   = bus.Next & ~r_nx_q & ~w_empty;
  // Popping the last entry with no capture alongside empties the buffer
  assign w_blank = w_pop & ~w_cap & (r_count == c_CNT_W'(1));
  // The head slot or head pointer moves; an emptying pop blanks instead
  assign w_head_upd = (w_pop | (w_cap & (w_empty | w_full))) & ~w_blank;

  assign w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  // Registered copies of the level inputs for rising-edge detection
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_rv_q <= 1'b0;
      r_nx_q <= 1'b0;
    end else begin
      r_rv_q <= bus.ResultValid;
      r_nx_q <= bus.Next;
    end
  end

  // Buffer storage; contents are only meaningful behind the pointers
  always_ff @(posedge Clock) begin
    if (w_cap) r_mem[r_wr_ptr] <= bus.DataResult;
  end

  // Pointers, occupancy, sticky overflow and the head-change strobe
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_head_chg <= 1'b0;
    end else begin
      r_head_chg <= w_head_upd;
      if (w_cap) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop || (w_cap && w_full)) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_cap && !w_pop && !w_full) r_count <= r_count + c_CNT_W'(1);
      else if (w_pop && !w_cap)       r_count <= r_count - c_CNT_W'(1);
      if (w_cap && !w_pop && w_full)  r_overflow <= 1'b1;
    end
  end

  // Conversion FSM state and pending flag
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Next state; a head change seen mid-conversion is remembered as pending
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    if ((r_state != S_IDLE) && r_head_chg) w_pending_nxt = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_head_chg || r_pending) begin
          w_state_nxt   = S_LOAD;
          w_pending_nxt = 1'b0;
        end
      end
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == c_CYC_W'(1)) w_state_nxt = S_DONE;
      S_DONE: begin
        if (r_head_chg || r_pending) begin
          w_state_nxt   = S_LOAD;
          w_pending_nxt = 1'b0;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Emptying the buffer abandons any conversion in flight
    if (w_blank) begin
      w_state_nxt   = S_IDLE;
      w_pending_nxt = 1'b0;
    end
  end

  // Shift-add-3 datapath and digit registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_hex0 <= c_BLANK;
      r_hex1 <= c_BLANK;
      r_hex2 <= c_BLANK;
    end else if (w_blank) begin
      r_hex0 <= c_BLANK;
      r_hex1 <= c_BLANK;
      r_hex2 <= c_BLANK;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_sh  <= r_mem[r_rd_ptr];
          r_bcd <= '0;
          r_cnt <= c_CYC_W'(DATA_W);
        end
        S_SHIFT: begin
          {r_bcd, r_sh} <= {w_bcd_adj, r_sh} << 1;
          r_cnt         <= r_cnt - c_CYC_W'(1);
        end
        S_DONE: begin
          r_hex0 <= seg7(r_bcd[3:0]);
          r_hex1 <= seg7(r_bcd[7:4]);
          r_hex2 <= seg7(r_bcd[11:8]);
        end
        default: ;
      endcase
    end
  end

  assign bus.HEX0     = r_hex0;
  assign bus.HEX1     = r_hex1;
  assign bus.HEX2     = r_hex2;
  assign bus.Count    = r_count;
  assign bus.Overflow = r_overflow;
  assign bus.Busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_display
// Brief    : Self-checking bench for result_bcd_display; directed scenarios
//            followed by random capture/pop traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_display;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic Clock = 1'b0;
  logic Resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_q[$];
  bit   model_ovf;

  result_bcd_display_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  result_bcd_display #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected segment pattern for decimal position pos (0=ones) of the head
  function automatic logic [6:0] exp_hex(input int pos);
    int v;
    if (model_q.size() == 0) return 7'h7F;
    v = model_q[0];
    case (pos)
      0:       return SEG[v % 10];
      1:       return SEG[(v / 10) % 10];
      default: return SEG[v / 100];
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_apply(input bit cap, input bit pop, input int val);
    bit p;
    p = pop && (model_q.size() != 0);
    if (p) model_q.delete(0);
    if (cap) begin
      if (!p && model_q.size() == DEPTH) begin
        model_q.delete(0);
        model_ovf = 1'b1;
      end
      model_q.push_back(val);
    end
  endtask

  task automatic op(input bit cap, input bit pop, input int val);
    bus.ResultValid = cap;
    bus.DataResult  = DATA_W'(val);
    bus.Next        = pop;
    tick();
    model_apply(cap, pop, val);
    bus.ResultValid = 1'b0;
    bus.Next        = 1'b0;
    tick();
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (2) tick();
    while (bus.Busy && n < 100) begin
      tick();
      n++;
    end
    check("settle_busy", bus.Busy, 0);
  endtask

  task automatic check_state(input string tag);
    check($sformatf("%s_count", tag), bus.Count, model_q.size());
    check($sformatf("%s_ovf", tag), bus.Overflow, model_ovf);
    check($sformatf("%s_hex0", tag), bus.HEX0, exp_hex(0));
    check($sformatf("%s_hex1", tag), bus.HEX1, exp_hex(1));
    check($sformatf("%s_hex2", tag), bus.HEX2, exp_hex(2));
  endtask

  task automatic do_reset();
    bus.ResultValid = 1'b0;
    bus.DataResult  = '0;
    bus.Next        = 1'b0;
    Resetn          = 1'b0;
    repeat (2) @(posedge Clock);
    #3 Resetn = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    tick();
  endtask

  initial begin
    int r;
    do_reset();
    check("rst_busy", bus.Busy, 0);
    check_state("rst");

    // Single capture of 137 with exact display latency
    bus.ResultValid = 1'b1;
    bus.DataResult  = 8'd137;
    tick();
    model_apply(1'b1, 1'b0, 137);
    bus.ResultValid = 1'b0;
    repeat (DATA_W + 2) tick();
    check("lat_early_hex0", bus.HEX0, 7'h7F);
    tick();
    check("c137_hex2", bus.HEX2, 7'h79);
    check("c137_hex1", bus.HEX1, 7'h30);
    check("c137_hex0", bus.HEX0, 7'h78);
    check("c137_busy", bus.Busy, 0);
    check("c137_count", bus.Count, 1);

    // Held-high ResultValid captures exactly once
    do_reset();
    bus.ResultValid = 1'b1;
    bus.DataResult  = 8'd42;
    repeat (50) tick();
    model_apply(1'b1, 1'b0, 42);
    bus.ResultValid = 1'b0;
    settle();
    check_state("hold42");

    // Overflow: five captures into a four-entry buffer, settled each time
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      op(1'b1, 1'b0, i * 10);
      settle();
    end
    check_state("ovf");
    check("ovf_head_hex1", bus.HEX1, SEG[2]);

    // 255 then 0, then pop twice down to empty
    do_reset();
    op(1'b1, 1'b0, 255);
    op(1'b1, 1'b0, 0);
    settle();
    check_state("d255");
    op(1'b0, 1'b1, 0);
    settle();
    check_state("d000");
    op(1'b0, 1'b1, 0);
    check("blank_hex0", bus.HEX0, 7'h7F);
    settle();
    check_state("dempty");

    // Simultaneous capture and pop while full
    do_reset();
    for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 100 + i);
    settle();
    op(1'b1, 1'b1, 105);
    settle();
    check_state("simul");

    // Back-to-back captures: overwrite during conversion goes through pending
    do_reset();
    for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, i * 10);
    settle();
    check_state("pend");

    // Pop during conversion also goes through pending
    do_reset();
    op(1'b1, 1'b0, 77);
    op(1'b1, 1'b0, 88);
    op(1'b0, 1'b1, 0);
    settle();
    check_state("pendpop");

    // Asynchronous reset in the middle of a conversion
    do_reset();
    for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, 200 + i);
    tick();
    check("pre_areset_busy", bus.Busy, 1);
    check("pre_areset_ovf", bus.Overflow, 1);
    #3 Resetn = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check("areset_busy", bus.Busy, 0);
    check_state("areset");
    #7 Resetn = 1'b1;
    tick();

    // Random traffic
    do_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      op(1'b1, 1'b0, $urandom_range(0, 255));
      else if (r <= 7) op(1'b0, 1'b1, 0);
      else if (r == 8) op(1'b1, 1'b1, $urandom_range(0, 255));
      else             tick();
      check("rnd_count", bus.Count, model_q.size());
      check("rnd_ovf", bus.Overflow, model_ovf);
      if ($urandom_range(0, 2) == 0) begin
        settle();
        check_state("rnd");
      end
    end
    settle();
    check_state("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
